// File: rtl/stage_pkg.sv
// Shared defaults and sizing helpers for the elastic buffer and its storage.
package stage_pkg;

  localparam int DATA_WIDTH_DEF = 36;
  localparam int DEPTH_DEF      = 4;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/buffer_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
module buffer_ram
  import stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_buffer.sv
// First-word fall-through FIFO with registered head, registered flags and flush.
// Handshake: a word moves on a rising edge when valid && ready; ready never depends on valid.
module elastic_buffer
  import stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [AW-1:0]         rd_ptr, wr_ptr, rd_nx, wr_nx;
  logic [LW-1:0]         level_nx;
  logic                  push, pop, head_load;
  logic [DATA_WIDTH-1:0] ram_rdata, head_data;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    rd_nx    = rd_ptr + AW'(pop);
    wr_nx    = wr_ptr + AW'(push);
    level_nx = level;
    case ({push, pop})
      2'b10:   level_nx = level + LW'(1);
      2'b01:   level_nx = level - LW'(1);
      default: level_nx = level;
    endcase
    // Head changes when the old head leaves or the first word lands in an empty buffer.
    head_load = (level_nx != '0) && (pop || (level == '0));
    // The new head may be the word being written this very edge (empty, or one entry streaming).
    head_data = (push && (wr_ptr == rd_nx)) ? data_in : ram_rdata;
  end

  buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push && rst && !flush),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_nx),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      data_out  <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      rd_ptr    <= rd_nx;
      wr_ptr    <= wr_nx;
      level     <= level_nx;
      out_valid <= (level_nx != '0);
      in_ready  <= (level_nx != LW'(DEPTH));
      if (head_load) data_out <= head_data;
    end
  end

endmodule
